// File: rtl/sba.sv
// ---------------------------------------------------------------------------
// sba: WIDTH-bit adder from 4-bit carry-lookahead groups, registered output.
// Optional signed-overflow output enabled by SBA_OVF_EN.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sba #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
`ifdef SBA_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NGRP = WIDTH / 4;

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_carry;   // carry into each bit; [WIDTH] is the final carry out
  logic [WIDTH-1:0] w_sum;

  assign w_g        = a & b;
  assign w_p        = a ^ b;
  assign w_carry[0] = cin;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    logic [3:0] w_gg;
    logic [3:0] w_pp;
    logic       w_ci;
    logic       w_grp_g;
    logic       w_grp_p;

    assign w_gg = w_g[4*gi +: 4];
    assign w_pp = w_p[4*gi +: 4];
    assign w_ci = w_carry[4*gi];

    assign w_carry[4*gi+1] = w_gg[0] | (w_pp[0] & w_ci);
    assign w_carry[4*gi+2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & w_ci);
    assign w_carry[4*gi+3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                           | (w_pp[2] & w_pp[1] & w_pp[0] & w_ci);

    assign w_grp_g = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
                   | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0]);
    assign w_grp_p = &w_pp;

    // Group carry-out ripples into the next group's carry-in.
    assign w_carry[4*gi+4] = w_grp_g | (w_grp_p & w_ci);
  end

  assign w_sum = w_p ^ w_carry[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= w_sum;
        cout <= w_carry[WIDTH];
      end
    end
  end

`ifdef SBA_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= w_carry[WIDTH-1] ^ w_carry[WIDTH];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sba.sv
// ---------------------------------------------------------------------------
// tb_sba: table-driven self-checking bench for sba, plus reset/hold sequences.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sba;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SBA_OVF_EN
  logic             ovf;
`endif

  int checks;
  int errors;

  sba #(.WIDTH(WIDTH)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .sum      (sum),
`ifdef SBA_OVF_EN
    .ovf      (ovf),
`endif
    .cout     (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] aa, input logic [15:0] bb, input logic cc);
    @(negedge clk);
    in_valid = v;
    a        = aa;
    b        = bb;
    cin      = cc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ovf(input string name, input logic exp);
`ifdef SBA_OVF_EN
    chk(name, {31'd0, ovf}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", name);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;

    //          a        b        cin  sum      cout  ovf
    vecs[0]  = {16'h0003, 16'h0002, 1'b0, 16'h0005, 1'b0, 1'b0};
    vecs[1]  = {16'h0007, 16'h0023, 1'b0, 16'h002A, 1'b0, 1'b0};
    vecs[2]  = {16'h0003, 16'h1003, 1'b1, 16'h1007, 1'b0, 1'b0};
    vecs[3]  = {16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vecs[4]  = {16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = {16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6]  = {16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7]  = {16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[8]  = {16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[9]  = {16'hABCD, 16'h5432, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[10] = {16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_sum", {16'd0, sum}, 32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
    chk_ovf("reset_ovf", 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back table vectors, one result per cycle.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_sum", i), {16'd0, sum}, {16'd0, vecs[i].exp_sum});
      chk($sformatf("vec%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].exp_cout});
      chk_ovf($sformatf("vec%0d_ovf", i), vecs[i].exp_ovf);
    end

    // Hold: in_valid low keeps sum/cout, drops out_valid.
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    chk("hold_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_sum", {16'd0, sum}, 32'h8000);
    chk("hold_cout", {31'd0, cout}, 32'd0);
    chk_ovf("hold_ovf", 1'b1);
    drive(1'b0, 16'h0001, 16'h0001, 1'b0);
    chk("hold2_sum", {16'd0, sum}, 32'h8000);

    // Async reset mid-stream with an operation pending.
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    chk("pre_rst_sum", {16'd0, sum}, 32'hFFFF);
    chk("pre_rst_cout", {31'd0, cout}, 32'd1);
    @(negedge clk);
    in_valid = 1'b1;
    a        = 16'h1111;
    b        = 16'h2222;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_sum", {16'd0, sum}, 32'd0);
    chk("async_rst_cout", {31'd0, cout}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_sum", {16'd0, sum}, 32'd0);
    drive(1'b0, 16'h0003, 16'h0002, 1'b0);
    chk("post_rst2_sum", {16'd0, sum}, 32'd0);

    // First valid result after reset release.
    drive(1'b1, 16'h0003, 16'h0002, 1'b0);
    chk("first_out_valid", {31'd0, out_valid}, 32'd1);
    chk("first_sum", {16'd0, sum}, 32'h0005);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("first_drop_valid", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
